load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 44 ++++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the CPU-side request/response signals and the data-memory port of
//   the load/store unit.
//
//   CPU side : req, we, size, sign, addr, wdata -> unit
//              rdata, ack, busy, misalign       <- unit
//   Memory   : mem_addr, mem_wdata, mem_we      <- unit
//              mem_rdata                        -> unit
//
//   Handshake: the requester raises req with stable operands and keeps them
//   until ack. ack is a one-cycle pulse that marks completion. While busy is
//   high, req and the operands are ignored. If req is still high in the idle
//   cycle after ack, a new access is accepted at that cycle's closing edge.
//
//   modport slave  : the load/store unit itself
//   modport master : the CPU plus data memory (e.g. a testbench)
// ---------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        misalign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, size, sign, addr, wdata, mem_rdata,
    output rdata, ack, busy, misalign, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, size, sign, addr, wdata, mem_rdata,
    input  rdata, ack, busy, misalign, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Byte, halfword and word loads/stores against a word-wide synchronous data
//   memory. Sub-word stores are read-modify-write. Lanes are little-endian.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous, active-high reset
//   bus       : load_store_unit_if.slave (CPU request/response + memory port)
//   dbg_state : current FSM state (state_t encoding)
//
// Flow (cycles counted from the accepting edge)
//   word store     : WR, DONE                 -> ack in cycle 2
//   load           : RD, CAP, DONE            -> ack in cycle 3
//   sub-word store : RD, CAP, WR, DONE        -> ack in cycle 4
//
// Configuration
//   MISALIGN_TRAP_EN : when defined, a halfword with addr[0]=1 or a word with
//   addr[1:0]!=0 skips straight to DONE with misalign=1 (no memory write,
//   rdata untouched). When undefined, misalign is 0 and such addresses are
//   force-aligned.
// ---------------------------------------------------------------------------
module load_store_unit (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;      // only the sub-word part is needed for the merge
  logic        we_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_wdata_q;
  logic        accept;
  logic        trap_hit;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept = (state_q == IDLE) && bus.req;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign trap_hit = ((bus.size == 2'b01) && bus.addr[0]) ||
                    (bus.size[1] && (bus.addr[1:0] != 2'b00));
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mis_q <= 1'b0;
    else if (accept) mis_q <= trap_hit;
  end
  assign bus.misalign = (state_q == DONE) && mis_q;
`else
  assign trap_hit     = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (trap_hit)                    state_d = DONE;
          else if (bus.we && bus.size[1])  state_d = WR;   // size 10/11 = word
          else                             state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores. Halfword
  // lane selection uses addr_q[1] only, which gives forced alignment.
  always_comb begin
    byte_lane = bus.mem_rdata[7:0];
    unique case (addr_q[1:0])
      2'd0: byte_lane = bus.mem_rdata[7:0];
      2'd1: byte_lane = bus.mem_rdata[15:8];
      2'd2: byte_lane = bus.mem_rdata[23:16];
      2'd3: byte_lane = bus.mem_rdata[31:24];
      default: byte_lane = bus.mem_rdata[7:0];
    endcase
    half_lane = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    unique case (size_q)
      2'b00:   load_val = {{24{sign_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{sign_q & half_lane[15]}}, half_lane};
      default: load_val = bus.mem_rdata;
    endcase

    merge_val = bus.mem_rdata;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        2'd3: merge_val[31:24] = wdata_q[7:0];
        default: merge_val = bus.mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q;
    end else begin
      merge_val[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      size_q      <= 2'b00;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata[15:0];
        we_q    <= bus.we;
        sign_q  <= bus.sign;
        size_q  <= bus.size;
        // Word stores bypass the read-modify-write, so the full word goes
        // straight to the memory write-data register.
        if (bus.we && bus.size[1] && !trap_hit) mem_wdata_q <= bus.wdata;
      end
      if (state_q == CAP) begin
        if (we_q) mem_wdata_q <= merge_val;
        else      rdata_q     <= load_val;
      end
    end
  end

  // mem_we is decoded from state alone so an asynchronous reset drops it
  // immediately.
  assign bus.mem_we    = (state_q == WR);
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.ack       = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Bench for load_store_unit with a 16-word synchronous data memory and a
//   byte-addressed reference model. Honours MISALIGN_TRAP_EN if defined.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- data memory ----------------
  logic [31:0] mem [16];
  logic        init_we;
  logic [3:0]  init_idx;
  logic [31:0] init_data;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (init_we)         mem[init_idx] <= init_data;
    else if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[5:2]];
    if (bus.mem_we) we_cnt <= we_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_bytes [64];
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  bit          trap_en;
  bit          prev_hold;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // ---------------- driver ----------------
  // Starts at a negedge with the DUT idle (or in DONE when the previous
  // access held req). Returns at the ack negedge if hold, else one cycle later.
  task automatic do_access(input bit w, input logic [1:0] sz, input bit sg,
                           input logic [5:0] a, input logic [31:0] wd, input bit hold);
    bit          mis;
    int          nb, base, exp_lat, lat, idle, we0;
    logic [31:0] v, full_addr;

    mis  = trap_en && (((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00)));
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a) - (int'(a) % nb);
    exp_lat = mis ? 1 : (w && nb == 4) ? 2 : w ? 4 : 3;

    if (!w) begin
      if (mis) begin
        v = last_rdata;
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[base+i]) << (8*i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      end
      last_rdata = v;
      exp_q.push_back(v);
    end else if (!mis) begin
      for (int i = 0; i < nb; i++) ref_bytes[base+i] = wd[8*i +: 8];
    end

    full_addr = {26'($urandom), a};
    bus.we    = w;
    bus.size  = sz;
    bus.sign  = sg;
    bus.addr  = full_addr;
    bus.wdata = wd;
    bus.req   = 1'b1;
    we0       = we_cnt;

    idle = 0;
    @(negedge clk);
    while (!bus.busy && idle < 10) begin
      idle++;
      @(negedge clk);
    end
    check("idle_gap", 32'(idle), prev_hold ? 32'd1 : 32'd0);

    lat = 1;
    while (!bus.ack && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("ack", {31'b0, bus.ack}, 32'd1);
    check("misalign", {31'b0, bus.misalign}, {31'b0, mis});
    check("mem_addr", bus.mem_addr, {full_addr[31:2], 2'b00});
    check("we_pulses", 32'(we_cnt - we0), (w && !mis) ? 32'd1 : 32'd0);
    check("mem_word", mem[a[5:2]], ref_word(int'(a[5:2])));
    if (!w) check("rdata", bus.rdata, exp_q.pop_front());
    else    check("rdata_hold", bus.rdata, last_rdata);

    prev_hold = hold;
    if (!hold) begin
      bus.req = 1'b0;
      @(negedge clk);
      check("ack_low", {30'b0, bus.ack, bus.busy}, 32'd0);
    end
  endtask

  // Starts an access from idle and pulses reset during cycle at_cycle.
  task automatic abort_access(input bit w, input logic [1:0] sz, input logic [5:0] a,
                              input logic [31:0] wd, input int at_cycle);
    int we0;
    bus.we    = w;
    bus.size  = sz;
    bus.sign  = 1'b0;
    bus.addr  = {26'd0, a};
    bus.wdata = wd;
    bus.req   = 1'b1;
    we0       = we_cnt;
    repeat (at_cycle) @(negedge clk);
    check("abort_busy_before", {31'b0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_ack", {31'b0, bus.ack}, 32'd0);
    check("abort_mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    prev_hold  = 1'b0;
    @(negedge clk);
    check("abort_we_pulses", 32'(we_cnt - we0), 32'd0);
    check("abort_mem_word", mem[a[5:2]], ref_word(int'(a[5:2])));
    check("abort_no_ack", {30'b0, bus.ack, bus.busy}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
`ifdef MISALIGN_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    prev_hold  = 1'b0;
    last_rdata = '0;
    rst        = 1'b1;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.size   = 2'b00;
    bus.sign   = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    init_we    = 1'b1;
    init_idx   = '0;
    init_data  = '0;

    for (int i = 0; i < 16; i++) begin
      init_idx  = 4'(i);
      init_data = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = init_data[8*b +: 8];
      @(negedge clk);
    end
    init_we = 1'b0;

    // reset state
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_ctl", {28'b0, bus.ack, bus.busy, bus.mem_we, bus.misalign}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // word store then word load
    do_access(1'b1, 2'b10, 1'b0, 6'h10, 32'hDEADBEEF, 1'b0);
    do_access(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 1'b0);
    check("lw_value", bus.rdata, 32'hDEADBEEF);

    // byte store, signed and unsigned byte loads
    do_access(1'b1, 2'b00, 1'b0, 6'h11, 32'h000000AA, 1'b0);
    check("sb_word", mem[4], 32'hDEADAAEF);
    do_access(1'b0, 2'b00, 1'b1, 6'h11, 32'h0, 1'b0);
    check("lb_value", bus.rdata, 32'hFFFFFFAA);
    do_access(1'b0, 2'b00, 1'b0, 6'h11, 32'h0, 1'b0);
    check("lbu_value", bus.rdata, 32'h000000AA);

    // halfword store and signed halfword load
    do_access(1'b1, 2'b01, 1'b0, 6'h12, 32'h00001234, 1'b0);
    check("sh_word", mem[4], 32'h1234AAEF);
    do_access(1'b0, 2'b01, 1'b1, 6'h12, 32'h0, 1'b0);
    check("lh_value", bus.rdata, 32'h00001234);

    // reset during CAP of a byte store, then during WR of a word store
    abort_access(1'b1, 2'b00, 6'h10, 32'h00000055, 2);
    check("abort_cap_word", mem[4], 32'h1234AAEF);
    abort_access(1'b1, 2'b10, 6'h10, 32'h0BADF00D, 1);
    check("abort_wr_word", mem[4], 32'h1234AAEF);

    // misaligned word load
    do_access(1'b0, 2'b10, 1'b0, 6'h13, 32'h0, 1'b0);

    // back-to-back with req held through ack
    do_access(1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 1'b1);
    do_access(1'b1, 2'b00, 1'b0, 6'h20, 32'h0000005A, 1'b1);
    do_access(1'b0, 2'b00, 1'b1, 6'h20, 32'h0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                $urandom, (n == 299) ? 1'b0 : ($urandom_range(0, 3) == 0));
    end

    // full memory sweep against the model
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_word(i));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
